// File: rtl/sat_counter_table_ctrl.sv
// ---------------------------------------------------------------------------
// sat_counter_table_ctrl
//
// Controller for a flip-flop table of 2-bit saturating counters.
//
// What it does:
//   - After reset, sweeps INIT_STATE into every entry.
//   - Arbitrates two update requesters onto the single write port, using
//     round-robin priority.
//   - Serves one registered lookup per cycle, with write-first bypass.
//
// Ports:
//   clk, rst_n                    clock (rising edge) and async active-low reset
//   init_done                     high once the init sweep has finished
//   lk_valid / lk_ready / lk_idx  lookup request handshake and index
//   lk_resp_valid                 lookup result valid, one cycle after acceptance
//   lk_state / lk_decision        looked-up counter state and its MSB
//   updN_valid / updN_ready       requester N update handshake (N = 0, 1)
//   updN_idx / updN_outcome       requester N entry index and outcome
// ---------------------------------------------------------------------------
module sat_counter_table_ctrl #(
   parameter int unsigned IDX_W      = 4,
   parameter logic [1:0]  INIT_STATE = 2'b11
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             init_done,
   input  logic             lk_valid,
   output logic             lk_ready,
   input  logic [IDX_W-1:0] lk_idx,
   output logic             lk_resp_valid,
   output logic [1:0]       lk_state,
   output logic             lk_decision,
   input  logic             upd0_valid,
   output logic             upd0_ready,
   input  logic [IDX_W-1:0] upd0_idx,
   input  logic             upd0_outcome,
   input  logic             upd1_valid,
   output logic             upd1_ready,
   input  logic [IDX_W-1:0] upd1_idx,
   input  logic             upd1_outcome
);

   localparam int unsigned   DEPTH    = 1 << IDX_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t           r_state;
   logic [IDX_W-1:0] r_ptr;
   logic             r_init_done;
   logic             r_prio;          // 0: requester 0 wins a tie, 1: requester 1
   logic [1:0]       r_table [DEPTH];
   logic             r_lk_resp_valid;
   logic [1:0]       r_lk_state;

   logic             w_run;
   logic             w_upd0_go;
   logic             w_upd1_go;
   logic             w_wr_en;
   logic [IDX_W-1:0] w_wr_idx;
   logic [1:0]       w_wr_data;
   logic             w_lk_accept;
   logic [1:0]       w_rd_data;

   // One saturating step toward 11 (outcome 1) or toward 00 (outcome 0).
   function automatic logic [1:0] sat_next(input logic [1:0] cur, input logic outcome);
      logic [1:0] nxt;
      if (outcome) begin
         if (cur == 2'b11) nxt = 2'b11;
         else              nxt = cur + 2'b01;
      end else begin
         if (cur == 2'b00) nxt = 2'b00;
         else              nxt = cur - 2'b01;
      end
      return nxt;
   endfunction

   // Arbitration, write-port selection and lookup read with write-first bypass.
   always_comb begin
      w_run     = (r_state == ST_RUN);
      w_upd0_go = w_run && upd0_valid && (!upd1_valid || !r_prio);
      w_upd1_go = w_run && upd1_valid && (!upd0_valid ||  r_prio);
      w_wr_en   = 1'b0;
      w_wr_idx  = '0;
      w_wr_data = 2'b00;
      if (!w_run) begin
         w_wr_en   = 1'b1;
         w_wr_idx  = r_ptr;
         w_wr_data = INIT_STATE;
      end else if (w_upd0_go) begin
         w_wr_en   = 1'b1;
         w_wr_idx  = upd0_idx;
         w_wr_data = sat_next(r_table[upd0_idx], upd0_outcome);
      end else if (w_upd1_go) begin
         w_wr_en   = 1'b1;
         w_wr_idx  = upd1_idx;
         w_wr_data = sat_next(r_table[upd1_idx], upd1_outcome);
      end else begin
         w_wr_en   = 1'b0;
      end
      w_lk_accept = lk_valid && r_init_done;
      // A write committing to the looked-up entry on the same edge is returned.
      if (w_wr_en && (w_wr_idx == lk_idx)) w_rd_data = w_wr_data;
      else                                 w_rd_data = r_table[lk_idx];
   end

   // Control FSM: init sweep, then run with round-robin priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_INIT;
         r_ptr       <= '0;
         r_init_done <= 1'b0;
         r_prio      <= 1'b0;
      end else begin
         case (r_state)
            ST_INIT: begin
               r_ptr <= r_ptr + IDX_W'(1);
               if (r_ptr == LAST_IDX) begin
                  r_state     <= ST_RUN;
                  r_init_done <= 1'b1;
               end
            end
            ST_RUN: begin
               // Service hands priority to the other requester.
               if (w_upd0_go)      r_prio <= 1'b1;
               else if (w_upd1_go) r_prio <= 1'b0;
            end
            default: begin
               r_state     <= ST_INIT;
               r_ptr       <= '0;
               r_init_done <= 1'b0;
               r_prio      <= 1'b0;
            end
         endcase
      end
   end

   // Counter table storage; contents are undefined until the sweep fills them.
   always_ff @(posedge clk) begin
      if (w_wr_en) r_table[w_wr_idx] <= w_wr_data;
   end

   // Registered lookup response; state holds when no lookup is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lk_resp_valid <= 1'b0;
         r_lk_state      <= 2'b00;
      end else begin
         r_lk_resp_valid <= w_lk_accept;
         if (w_lk_accept) r_lk_state <= w_rd_data;
      end
   end

   assign init_done     = r_init_done;
   assign lk_ready      = r_init_done;
   assign upd0_ready    = w_upd0_go;
   assign upd1_ready    = w_upd1_go;
   assign lk_resp_valid = r_lk_resp_valid;
   assign lk_state      = r_lk_state;
   assign lk_decision   = r_lk_state[1];

endmodule

// File: tb/tb_sat_counter_table_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sat_counter_table_ctrl
//
// Directed, self-checking bench for sat_counter_table_ctrl (IDX_W = 4).
// Expected lookup results are pushed into a queue when a lookup is driven.
// They are popped and compared when the response appears.
// ---------------------------------------------------------------------------
module tb_sat_counter_table_ctrl;

   logic       clk;
   logic       rst_n;
   logic       init_done;
   logic       lk_valid;
   logic       lk_ready;
   logic [3:0] lk_idx;
   logic       lk_resp_valid;
   logic [1:0] lk_state;
   logic       lk_decision;
   logic       upd0_valid;
   logic       upd0_ready;
   logic [3:0] upd0_idx;
   logic       upd0_outcome;
   logic       upd1_valid;
   logic       upd1_ready;
   logic [3:0] upd1_idx;
   logic       upd1_outcome;

   int         total;
   int         bad;
   logic [1:0] sb_q[$];

   sat_counter_table_ctrl #(.IDX_W(4), .INIT_STATE(2'b11)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .init_done     (init_done),
      .lk_valid      (lk_valid),
      .lk_ready      (lk_ready),
      .lk_idx        (lk_idx),
      .lk_resp_valid (lk_resp_valid),
      .lk_state      (lk_state),
      .lk_decision   (lk_decision),
      .upd0_valid    (upd0_valid),
      .upd0_ready    (upd0_ready),
      .upd0_idx      (upd0_idx),
      .upd0_outcome  (upd0_outcome),
      .upd1_valid    (upd1_valid),
      .upd1_ready    (upd1_ready),
      .upd1_idx      (upd1_idx),
      .upd1_outcome  (upd1_outcome)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Check a response is present and matches the oldest queued expectation.
   task automatic check_resp(input string tag);
      logic [1:0] e;
      chk({tag, "_rv"}, 8'(lk_resp_valid), 8'h01);
      if (sb_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 8'h01, 8'h00);
      end else begin
         e = sb_q.pop_front();
         chk({tag, "_state"}, 8'(lk_state), 8'(e));
         chk({tag, "_dec"}, 8'(lk_decision), 8'(e[1]));
      end
   endtask

   // Single lookup, response checked one cycle later.
   task automatic lookup(input logic [3:0] idx, input logic [1:0] exp, input string tag);
      lk_valid = 1'b1;
      lk_idx   = idx;
      sb_q.push_back(exp);
      tick();
      lk_valid = 1'b0;
      check_resp(tag);
   endtask

   // Single update by requester 0 (alone on the bus, so granted at once).
   task automatic upd0(input logic [3:0] idx, input logic outcome, input string tag);
      upd0_valid   = 1'b1;
      upd0_idx     = idx;
      upd0_outcome = outcome;
      #1;
      chk({tag, "_rdy"}, 8'(upd0_ready), 8'h01);
      tick();
      upd0_valid = 1'b0;
   endtask

   // Release reset and follow the sweep edge by edge with requests pending.
   task automatic sweep(input string tag);
      upd0_valid = 1'b1; upd0_idx = 4'd1; upd0_outcome = 1'b0;
      upd1_valid = 1'b1; upd1_idx = 4'd2; upd1_outcome = 1'b0;
      lk_valid   = 1'b1; lk_idx   = 4'd0;
      rst_n = 1'b1;
      #1;
      chk({tag, "_done_e0"}, 8'(init_done), 8'h00);
      for (int e = 1; e <= 16; e++) begin
         tick();
         if (e < 16) begin
            chk($sformatf("%s_done_e%0d", tag, e), 8'(init_done), 8'h00);
            chk($sformatf("%s_rdys_e%0d", tag, e),
                8'({lk_ready, upd0_ready, upd1_ready, lk_resp_valid}), 8'h00);
         end else begin
            chk($sformatf("%s_done_e%0d", tag, e), 8'(init_done), 8'h01);
            chk($sformatf("%s_lkrdy_e%0d", tag, e), 8'(lk_ready), 8'h01);
         end
      end
      upd0_valid = 1'b0;
      upd1_valid = 1'b0;
      lk_valid   = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      lk_valid = 1'b0; lk_idx = 4'd0;
      upd0_valid = 1'b0; upd0_idx = 4'd0; upd0_outcome = 1'b0;
      upd1_valid = 1'b0; upd1_idx = 4'd0; upd1_outcome = 1'b0;

      // Reset values.
      #12;
      chk("rst_outputs",
          8'({init_done, lk_ready, upd0_ready, upd1_ready, lk_resp_valid, lk_state, lk_decision}),
          8'h00);

      // Init sweep: init_done rises on the 16th edge, readies held low.
      sweep("init");

      // Back-to-back lookups of every entry, all at INIT_STATE.
      lk_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         lk_idx = 4'(i);
         sb_q.push_back(2'b11);
         tick();
         check_resp($sformatf("sweep_lk%0d", i));
      end
      lk_valid = 1'b0;
      tick();
      chk("idle_rv", 8'(lk_resp_valid), 8'h00);
      chk("idle_hold", 8'(lk_state), 8'h03);

      // Contention: grants alternate 0,1,0,1,0,1 starting from requester 0.
      upd0_valid = 1'b1; upd0_idx = 4'd2; upd0_outcome = 1'b0;
      upd1_valid = 1'b1; upd1_idx = 4'd3; upd1_outcome = 1'b0;
      for (int c = 0; c < 6; c++) begin
         #1;
         chk($sformatf("cont_g%0d", c), 8'({upd0_ready, upd1_ready}),
             (c % 2 == 0) ? 8'h02 : 8'h01);
         tick();
      end
      // Priority rests with requester 0: check the tie combinationally, no edge.
      #1;
      chk("cont_prio_rest", 8'({upd0_ready, upd1_ready}), 8'h02);
      upd0_valid = 1'b0;
      upd1_valid = 1'b0;
      #1;
      chk("cont_none", 8'({upd0_ready, upd1_ready}), 8'h00);
      lookup(4'd2, 2'b00, "cont_idx2");
      lookup(4'd3, 2'b00, "cont_idx3");

      // Saturation toward 00 on idx 5, then climb back.
      upd0(4'd5, 1'b0, "sat_d1"); lookup(4'd5, 2'b10, "sat_d1");
      upd0(4'd5, 1'b0, "sat_d2"); lookup(4'd5, 2'b01, "sat_d2");
      upd0(4'd5, 1'b0, "sat_d3"); lookup(4'd5, 2'b00, "sat_d3");
      upd0(4'd5, 1'b0, "sat_d4"); lookup(4'd5, 2'b00, "sat_d4");
      upd0(4'd5, 1'b1, "sat_u1"); lookup(4'd5, 2'b01, "sat_u1");
      upd0(4'd5, 1'b1, "sat_u2"); lookup(4'd5, 2'b10, "sat_u2");
      // Saturation at 11: idx 6 is still 11 from init.
      upd0(4'd6, 1'b1, "sat_top"); lookup(4'd6, 2'b11, "sat_top");

      // Write-first bypass: update and lookup of idx 7 on the same edge.
      upd1_valid = 1'b1; upd1_idx = 4'd7; upd1_outcome = 1'b0;
      lk_valid   = 1'b1; lk_idx   = 4'd7;
      sb_q.push_back(2'b10);
      #1;
      chk("byp_rdy", 8'(upd1_ready), 8'h01);
      tick();
      upd1_valid = 1'b0;
      lk_valid   = 1'b0;
      check_resp("byp");

      // Reset mid-operation with requests pending.
      upd0_valid = 1'b1; upd0_idx = 4'd9; upd0_outcome = 1'b1;
      upd1_valid = 1'b1; upd1_idx = 4'd10; upd1_outcome = 1'b1;
      lk_valid   = 1'b1; lk_idx   = 4'd0;
      tick();
      chk("pre_rst_rv", 8'(lk_resp_valid), 8'h01);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_outputs",
          8'({init_done, lk_ready, upd0_ready, upd1_ready, lk_resp_valid, lk_state, lk_decision}),
          8'h00);
      sb_q.delete();
      #2;
      sweep("reinit");
      lookup(4'd2, 2'b11, "reinit_idx2");
      lookup(4'd5, 2'b11, "reinit_idx5");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sat_counter_table_ctrl.md
Name: sat_counter_table_ctrl

Overview:
Controller for a table of 2-bit saturating trust/prediction counters. Each entry behaves as a 4-state evaluator: states 00, 01, 10, 11. Outcome 1 moves one step toward 11, outcome 0 moves one step toward 00. The decision output is 1 when the state is 10 or 11.
The block does three jobs:
- Initialises the whole table after reset.
- Arbitrates two update requesters onto the table's single write port.
- Serves one registered lookup per cycle, for use by the core's prediction/trust logic.

Parameters:
IDX_W, 4, index width; table depth DEPTH = 2^IDX_W entries.
INIT_STATE, 2'b11, value written to every entry during the init sweep.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
init_done  output  1  high once the init sweep completes; stays high until the next reset.
lk_valid  input  1  lookup request.
lk_ready  output  1  lookup accepted when lk_valid && lk_ready.
lk_idx  input  IDX_W  lookup index.
lk_resp_valid  output  1  lookup result valid, one cycle after acceptance.
lk_state  output  2  looked-up counter state.
lk_decision  output  1  equals lk_state[1].
upd0_valid  input  1  requester 0 update request.
upd0_ready  output  1  requester 0 grant.
upd0_idx  input  IDX_W  requester 0 entry index.
upd0_outcome  input  1  requester 0 outcome; 1 = truthful/taken.
upd1_valid  input  1  requester 1 update request.
upd1_ready  output  1  requester 1 grant.
upd1_idx  input  IDX_W  requester 1 entry index.
upd1_outcome  input  1  requester 1 outcome.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values while rst_n=0:
  - init_done=0, lk_ready=0, upd0_ready=0, upd1_ready=0.
  - lk_resp_valid=0, lk_state=2'b00, lk_decision=0.
  - init pointer=0; round-robin priority = requester 0.
  - Table contents are don't-care.
- Control FSM has two states, INIT and RUN; reset enters INIT.
- INIT state:
  - Each rising edge writes INIT_STATE to entry[ptr] and increments ptr.
  - The edge that writes entry DEPTH-1 moves the FSM to RUN and sets init_done=1.
  - init_done therefore rises after exactly DEPTH edges with rst_n=1.
  - All ready outputs are 0 in INIT; requests are ignored, not queued.
- Reset mid-operation (any time): asynchronously return to reset values. The next rst_n release restarts the sweep from entry 0, and pending handshakes are dropped.
- RUN, update arbitration:
  - Readies are combinational from the valids and the priority register.
  - Only one valid: that requester gets ready=1.
  - Both valid: the priority holder gets ready=1 and the other gets 0.
  - Neither valid: both readies 0; priority unchanged.
  - On a completed handshake by requester k, priority passes to the other requester at that edge. Alternating service is guaranteed under continuous contention.
  - Requesters hold valid, idx and outcome stable until their handshake.
- Update arithmetic, at most one entry per edge:
  - Outcome 1: 00→01→10→11, then 11 saturates at 11.
  - Outcome 0: 11→10→01→00, then 00 saturates at 00.
  - No wrap-around in either direction.
- Lookup path:
  - lk_ready = init_done.
  - On an accepting edge, the next cycle has lk_resp_valid=1 and lk_state = entry[lk_idx] as written at that same edge.
  - Write-first bypass: if an update to lk_idx commits on the accepting edge, the updated value is returned.
  - Latency is 1 cycle; back-to-back lookups are accepted every cycle.
  - If no lookup is accepted, lk_resp_valid=0 next cycle, and lk_state/lk_decision hold their last values.
- Table storage is flip-flops, DEPTH x 2 bits; one write port (init or arbitrated update) and one read port.

Test Plan:
- Release rst_n with IDX_W=4 → init_done=0 for 15 edges and 1 after the 16th. All readies 0 throughout INIT. A lookup of idx 0..15 afterwards returns lk_state=2'b11, lk_decision=1.
- Saturation on idx 5 (after init, state 11):
  - Four outcome-0 updates → lookups return 10, 01, 00, 00; decision 1, 0, 0, 0.
  - Then two outcome-1 updates → lookups return 01, then 10 with decision=1.
- Contention: upd0 and upd1 held valid for 6 cycles, to idx 2 and idx 3, both outcome 0 → grants alternate 0,1,0,1,0,1. Final states: idx2=00, idx3=00. Priority then rests with requester 0.
- Bypass: upd1 (idx 7, outcome 0) and lookup of idx 7 on the same edge, entry previously 11 → next cycle lk_resp_valid=1, lk_state=10, lk_decision=1.
- Reset mid-op: assert rst_n=0 during RUN with requests pending → all outputs go to reset values immediately, without waiting for a clk edge. After release, the 16-cycle sweep repeats and idx 2 reads back 11.
